store_rmw_sequencer: RTL and testbench
======================================

// Module: store_rmw_sequencer
// PURPOSE
//  Read-modify-write sequencer for sb/sh/sw in the multicycle datapath. It takes a store request
//  (address, RegB, size), fetches the current memory word when a partial store needs it, merges
//  the low byte/half of RegB into that word and writes the result back. It sits between the
//  control unit and data memory, replacing the separate control-unit states for memory read and write.
// PARAMETERS
//  MEM_LAT  1  data-memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after mem_addr
//  ADDR_W   32 width of mem_addr / addr
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       request strobe, sampled only in IDLE
//  st_size    in   2       1=byte, 2=half, 3=word, 0=illegal
//  addr       in   ADDR_W  store address
//  regb       in   32      store data (RegB)
//  mem_rdata  in   32      data-memory read data
//  mem_addr   out  ADDR_W  data-memory address
//  mem_wdata  out  32      data-memory write data
//  mem_wr     out  1       data-memory write enable, 1 cycle per store
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse, store completed
//  err        out  1       1-cycle pulse, illegal size or misaligned, no write performed
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, all outputs 0, internal regs 0. Mid-operation reset
//    aborts immediately: mem_wr drops asynchronously, no partial write is issued, and no done is produced.
//  - All outputs are decoded from registered state/regs only; no input->output combinational path.
//  - IDLE: on start, latch addr_q, regb_q, size_q. Next state:
//      size==0, half with addr[0]!=0, or word with addr[1:0]!=0 -> ERR;
//      size==3 -> WRITE; size 1/2 -> READ with cnt=MEM_LAT.
//    start while busy is ignored, not queued.
//  - READ: mem_addr=addr_q, mem_wr=0. Stay for MEM_LAT+1 cycles. On the edge that ends the last
//    READ cycle, register mem_rdata into word_q. Then go to WRITE.
//  - WRITE (1 cycle): mem_addr=addr_q, mem_wr=1, mem_wdata=merge(word_q, regb_q, size_q). Then go to DONE.
//  - DONE (1 cycle): done=1, then go to IDLE. ERR (1 cycle): err=1, mem_wr stays 0, then go to IDLE.
//  - Merge: byte -> {word_q[31:8], regb_q[7:0]}; half -> {word_q[31:16], regb_q[15:0]};
//    word -> regb_q (word_q is unused, memory is not read).
//  - Latency (start edge = cycle 0): sw -> mem_wr in cycle 1, done in cycle 2;
//    sb/sh -> mem_wr in cycle MEM_LAT+2, done in cycle MEM_LAT+3; err in cycle 1.
//  - mem_addr=0 and mem_wdata=0 in IDLE, DONE and ERR. busy=0 only in IDLE, so busy falls the
//    cycle after done/err and a new start may be accepted that same cycle.
//  - Inputs addr/regb/st_size may change freely after the start cycle; only latched copies are used.
// STRUCTURE
//  - Shared package store_pkg:
//      size codes SZ_ILL=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3;
//      state encoding IDLE, READ, WRITE, DONE, ERR.
//    The control unit imports the same codes.
//  - One combinational sub-module, store_merge(word_in, regb, size) -> merged word, reused by any
//    future store path.
//  - Latency counter width is $clog2(MEM_LAT+2).
// TESTING
//  1. sw: addr=0x10, regb=0xDEADBEEF, size=3 -> mem_wr in cycle 1, mem_wdata=0xDEADBEEF, mem_addr=0x10,
//     no read cycle, done in cycle 2.
//  2. sb: addr=0x20, regb=0x123456AB, mem word=0x11223344, MEM_LAT=1 -> mem_wdata=0x112233AB,
//     mem_wr in cycle 3, done in cycle 4.
//  3. sh: addr=0x22, regb=0xFFFFCAFE, mem word=0xA0B0C0D0 -> mem_wdata=0xA0B0CAFE.
//     Repeat with MEM_LAT=3 -> mem_wr in cycle 5.
//  4. Errors, each with mem_wr never asserted and err pulse in cycle 1:
//     size=0; sh at addr=0x21; sw at addr=0x12.
//  5. Reset pulled low during READ of a sb -> busy=0 and mem_wr=0 immediately, no done.
//     A later sw completes normally.
//  6. start held high across an sb and pulsed again mid-READ -> exactly one write and one done.
//     Back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/store_rmw_sequencer_pkg.sv
// Shared store definitions: access size codes, sequencer state encoding and
// the alignment check used when a store request is accepted.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_ILL  = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    // A request is rejected for an illegal size or a half/word not naturally aligned.
    function automatic logic size_addr_bad(input logic [1:0] sz, input logic [1:0] a_lo);
        logic bad;
        case (sz)
            SZ_ILL:  bad = 1'b1;
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a_lo[0];
            SZ_WORD: bad = (a_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_rmw_sequencer_merge.sv
// Combinational merge of the low byte/half of the store data into a memory word.
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] regb,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    // Select which lanes come from the store data and which from the old word.
    always_comb begin
        merged = regb;
        case (size)
            SZ_BYTE: merged = {word_in[31:8], regb[7:0]};
            SZ_HALF: merged = {word_in[31:16], regb[15:0]};
            SZ_WORD: merged = regb;
            default: merged = regb;
        endcase
    end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Read-modify-write store sequencer: fetches the memory word for sb/sh,
// merges the store data into it and writes it back; sw writes directly.
module store_rmw_sequencer
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       regb,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_LAT + 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       regb_q, regb_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       merged_s;

    store_merge u_merge (
        .word_in (word_q),
        .regb    (regb_q),
        .size    (size_q),
        .merged  (merged_s)
    );

    // State and request registers; reset aborts any store in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            regb_q  <= 32'h0;
            size_q  <= 2'b00;
            word_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            regb_q  <= regb_d;
            size_q  <= size_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the read counter spans MEM_LAT+1 READ cycles.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        regb_d  = regb_q;
        size_d  = size_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = addr;
                    regb_d = regb;
                    size_d = st_size;
                    if (size_addr_bad(st_size, addr[1:0])) begin
                        state_d = ERR;
                    end else if (st_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                        cnt_d   = CNT_W'(MEM_LAT);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    word_d  = mem_rdata;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            READ: mem_addr = addr_q;
            WRITE: begin
                mem_addr  = addr_q;
                mem_wdata = merged_s;
                mem_wr    = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: mem_wr = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer with MEM_LAT=1 and MEM_LAT=3 instances.
module tb_store_rmw_sequencer;

    logic        clk, rst_n, start1, start3;
    logic [1:0]  st_size;
    logic [31:0] addr, regb, mem_word;
    logic [31:0] rd1, rd3, p3a, p3b;
    logic [31:0] maddr1, mwdata1, maddr3, mwdata3;
    logic        wr1, busy1, done1, err1, wr3, busy3, done3, err3;

    int vectors = 0;
    int miscompares = 0;

    bit          sel3;
    logic [31:0] o_addr, o_wdata;
    logic        o_wr, o_busy, o_done, o_err;
    int          wr_cyc, done_cyc, err_cyc, wr_cnt, done_cnt, err_cnt;
    logic [31:0] wr_data, wr_addr;
    int          seen;

    store_rmw_sequencer #(.MEM_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .st_size(st_size), .addr(addr),
        .regb(regb), .mem_rdata(rd1), .mem_addr(maddr1), .mem_wdata(mwdata1),
        .mem_wr(wr1), .busy(busy1), .done(done1), .err(err1)
    );

    store_rmw_sequencer #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(rst_n), .start(start3), .st_size(st_size), .addr(addr),
        .regb(regb), .mem_rdata(rd3), .mem_addr(maddr3), .mem_wdata(mwdata3),
        .mem_wr(wr3), .busy(busy3), .done(done3), .err(err3)
    );

    assign o_addr  = sel3 ? maddr3  : maddr1;
    assign o_wdata = sel3 ? mwdata3 : mwdata1;
    assign o_wr    = sel3 ? wr3     : wr1;
    assign o_busy  = sel3 ? busy3   : busy1;
    assign o_done  = sel3 ? done3   : done1;
    assign o_err   = sel3 ? err3    : err1;

    always #5 clk = ~clk;

    // Memory model: read data valid exactly MEM_LAT cycles after a read address.
    always @(posedge clk) begin
        rd1 <= (maddr1 != 32'h0 && !wr1) ? mem_word : 32'hBAD0BAD0;
        p3a <= (maddr3 != 32'h0 && !wr3) ? mem_word : 32'hBAD0BAD0;
        p3b <= p3a;
        rd3 <= p3b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge and observe ncyc following cycles.
    task automatic run(input bit use3, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input int ncyc);
        sel3 = use3; st_size = sz; addr = a; regb = d;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        wr_cyc = -1; done_cyc = -1; err_cyc = -1;
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; wr_data = 32'h0; wr_addr = 32'h0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) begin addr = ~a; regb = ~d; st_size = 2'd0; end
            if (k == hold) begin start1 = 1'b0; start3 = 1'b0; end
            if (o_wr) begin
                wr_cnt++;
                if (wr_cyc < 0) wr_cyc = k;
                wr_data = o_wdata; wr_addr = o_addr;
            end
            if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
            if (o_err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = k;  end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
        st_size = 2'd0; addr = 32'h0; regb = 32'h0; mem_word = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy1", busy1, 32'd0);   chk("rst_wr1", wr1, 32'd0);
        chk("rst_done1", done1, 32'd0);   chk("rst_err1", err1, 32'd0);
        chk("rst_addr1", maddr1, 32'h0);  chk("rst_wdata1", mwdata1, 32'h0);
        chk("rst_busy3", busy3, 32'd0);   chk("rst_wr3", wr3, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // sw: direct write, no read
        run(1'b0, 2'd3, 32'h10, 32'hDEADBEEF, 1, 4);
        chk("sw_wr_cyc", wr_cyc, 32'd1);       chk("sw_wdata", wr_data, 32'hDEADBEEF);
        chk("sw_waddr", wr_addr, 32'h10);      chk("sw_done_cyc", done_cyc, 32'd2);
        chk("sw_wr_cnt", wr_cnt, 32'd1);       chk("sw_idle_busy", o_busy, 32'd0);

        // sb, MEM_LAT=1
        mem_word = 32'h11223344;
        run(1'b0, 2'd1, 32'h20, 32'h123456AB, 1, 6);
        chk("sb_wr_cyc", wr_cyc, 32'd3);       chk("sb_wdata", wr_data, 32'h112233AB);
        chk("sb_waddr", wr_addr, 32'h20);      chk("sb_done_cyc", done_cyc, 32'd4);

        // sh, MEM_LAT=1 and MEM_LAT=3
        mem_word = 32'hA0B0C0D0;
        run(1'b0, 2'd2, 32'h22, 32'hFFFFCAFE, 1, 6);
        chk("sh1_wr_cyc", wr_cyc, 32'd3);      chk("sh1_wdata", wr_data, 32'hA0B0CAFE);
        run(1'b1, 2'd2, 32'h22, 32'hFFFFCAFE, 1, 8);
        chk("sh3_wr_cyc", wr_cyc, 32'd5);      chk("sh3_wdata", wr_data, 32'hA0B0CAFE);
        chk("sh3_done_cyc", done_cyc, 32'd6);  chk("sh3_waddr", wr_addr, 32'h22);
        chk("sh3_idle_busy", o_busy, 32'd0);

        // error cases
        run(1'b0, 2'd0, 32'h30, 32'h1, 1, 4);
        chk("e0_err_cyc", err_cyc, 32'd1);     chk("e0_wr_cnt", wr_cnt, 32'd0);
        chk("e0_done_cnt", done_cnt, 32'd0);
        run(1'b0, 2'd2, 32'h21, 32'h2, 1, 4);
        chk("eh_err_cyc", err_cyc, 32'd1);     chk("eh_wr_cnt", wr_cnt, 32'd0);
        run(1'b0, 2'd3, 32'h12, 32'h3, 1, 4);
        chk("ew_err_cyc", err_cyc, 32'd1);     chk("ew_wr_cnt", wr_cnt, 32'd0);
        chk("ew_err_cnt", err_cnt, 32'd1);

        // reset during READ of an sb
        sel3 = 1'b0; mem_word = 32'h55555555;
        st_size = 2'd1; addr = 32'h40; regb = 32'h77; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("rr_busy_pre", busy1, 32'd1);
        rst_n = 1'b0; #1;
        chk("rr_busy", busy1, 32'd0);          chk("rr_wr", wr1, 32'd0);
        seen = 0;
        for (int k = 0; k < 2; k++) begin @(negedge clk); if (done1 || wr1) seen++; end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (done1 || wr1) seen++; end
        chk("rr_no_done", seen, 32'd0);
        run(1'b0, 2'd3, 32'h44, 32'hA5A5A5A5, 1, 4);
        chk("rr_sw_wr_cyc", wr_cyc, 32'd1);    chk("rr_sw_wdata", wr_data, 32'hA5A5A5A5);

        // reset during WRITE drops mem_wr at once
        st_size = 2'd3; addr = 32'h48; regb = 32'h1; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("rw_wr_pre", wr1, 32'd1);
        rst_n = 1'b0; #1;
        chk("rw_wr", wr1, 32'd0);              chk("rw_addr", maddr1, 32'h0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // start held high through the store, then back-to-back sw
        mem_word = 32'hCAFEBABE;
        run(1'b0, 2'd1, 32'h50, 32'h000000EE, 4, 8);
        chk("hold_wr_cnt", wr_cnt, 32'd1);     chk("hold_done_cnt", done_cnt, 32'd1);
        chk("hold_wdata", wr_data, 32'hCAFEBAEE);
        run(1'b0, 2'd3, 32'h60, 32'h01020304, 1, 3);
        chk("b2b_a_done", done_cyc, 32'd2);
        run(1'b0, 2'd3, 32'h64, 32'h55667788, 1, 3);
        chk("b2b_b_wr_cyc", wr_cyc, 32'd1);    chk("b2b_b_wdata", wr_data, 32'h55667788);
        chk("b2b_b_waddr", wr_addr, 32'h64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
